// File: rtl/hifp_pkg.sv
// Shared types and helpers for the HIFP window fingerprint block.
// The optional result store-back is enabled with `define HIFP_STORE_EN.
package hifp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ACC,
      S_ST,
      S_ACK,
      S_OUT
   } state_t;

   localparam int unsigned MODE_SUM    = 0;
   localparam int unsigned MODE_HASH   = 1;
   localparam int unsigned ROT_DEFAULT = 5;

   // 32-bit left rotate; amount taken modulo 32
   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      int unsigned s;
      s = n % 32;
      return (s == 0) ? x : ((x << s) | (x >> (32 - s)));
   endfunction

endpackage

// File: rtl/hifp_fold.sv
// Combinational one-beat fold: lanes are folded lane 0 first by wrapping sum
// or rotate-XOR hash.
module hifp_fold
   import hifp_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned MEM_W  = 512,
   parameter int unsigned MODE   = MODE_HASH,
   parameter int unsigned ROT    = ROT_DEFAULT
) (
   input  logic [DATA_W-1:0] acc_in,
   input  logic [MEM_W-1:0]  beat,
   output logic [DATA_W-1:0] acc_out
);

   localparam int unsigned LANES = MEM_W / DATA_W;

   logic [DATA_W-1:0] acc_v;
   logic [DATA_W-1:0] word;

   always_comb begin
      acc_v = acc_in;
      word  = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         word = beat[i*DATA_W +: DATA_W];
         if (MODE == MODE_SUM)
            acc_v = acc_v + word;
         else
            acc_v = ((acc_v << ROT) | (acc_v >> (DATA_W - ROT))) ^ word;
      end
      acc_out = acc_v;
   end

endmodule

// File: rtl/hifp_rtl_window.sv
// Window fingerprint: burst-reads WIN_BEATS beats, folds them into one word and
// returns it on the kernel stream; `define HIFP_STORE_EN adds the write-back.
module hifp_rtl_window
   import hifp_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_W     = 512,
   parameter int unsigned WIN_BEATS = 4,
   parameter int unsigned MODE      = MODE_HASH,
   parameter int unsigned ROT       = ROT_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 m_valid_in,
   output logic                 m_ready_out,
   input  logic [31:0]          m_input_global_id_0,
   input  logic [31:0]          m_input_wave,
   input  logic [31:0]          m_input_global_size_0,
   input  logic [31:0]          m_input_fpid,
   output logic [DATA_W-1:0]    m_output_0,
   output logic                 m_valid_out,
   input  logic                 m_ready_in,
   output logic [31:0]          avm_local_bb1_ld__address,
   output logic                 avm_local_bb1_ld__read,
   output logic [4:0]           avm_local_bb1_ld__burstcount,
   input  logic                 avm_local_bb1_ld__waitrequest,
   input  logic [MEM_W-1:0]     avm_local_bb1_ld__readdata,
   input  logic                 avm_local_bb1_ld__readdatavalid,
   output logic [31:0]          avm_local_bb1_st__address,
   output logic                 avm_local_bb1_st__write,
   output logic [MEM_W-1:0]     avm_local_bb1_st__writedata,
   output logic [MEM_W/8-1:0]   avm_local_bb1_st__byteenable,
   input  logic                 avm_local_bb1_st__waitrequest,
   input  logic                 avm_local_bb1_st__writeack
);

   localparam int unsigned LANES      = MEM_W / DATA_W;
   localparam int unsigned BEAT_BYTES = MEM_W / 8;
   localparam int unsigned LANE_BYTES = DATA_W / 8;
   localparam int unsigned WIN_BYTES  = WIN_BEATS * BEAT_BYTES;
   localparam int unsigned BE_W       = MEM_W / 8;
   localparam int unsigned CNT_W      = 5;

   state_t              state;
   logic [DATA_W-1:0]   acc;
   logic [DATA_W-1:0]   acc_next;
   logic [CNT_W-1:0]    beat_cnt;
   logic                last_beat;

   hifp_fold #(
      .DATA_W (DATA_W),
      .MEM_W  (MEM_W),
      .MODE   (MODE),
      .ROT    (ROT)
   ) u_fold (
      .acc_in  (acc),
      .beat    (avm_local_bb1_ld__readdata),
      .acc_out (acc_next)
   );

   assign avm_local_bb1_ld__burstcount = 5'(WIN_BEATS);
   assign last_beat = (beat_cnt == CNT_W'(WIN_BEATS - 1));

`ifdef HIFP_STORE_EN
   logic [31:0]      id_q;
   logic [31:0]      wave_q;
   logic [31:0]      size_q;
   logic [31:0]      lane_c;
   logic [31:0]      st_addr_c;
   logic [BE_W-1:0]  be_c;

   // result region follows all windows; each item owns one DATA_W lane
   assign lane_c    = id_q % 32'(LANES);
   assign st_addr_c = wave_q + size_q * 32'(WIN_BYTES) + (id_q / 32'(LANES)) * 32'(BEAT_BYTES);
   assign be_c      = BE_W'({LANE_BYTES{1'b1}}) << (lane_c * 32'(LANE_BYTES));
`else
   logic unused_st;
   assign unused_st = ^{avm_local_bb1_st__waitrequest, avm_local_bb1_st__writeack,
                        m_input_global_size_0};

   assign avm_local_bb1_st__address    = '0;
   assign avm_local_bb1_st__write      = 1'b0;
   assign avm_local_bb1_st__writedata  = '0;
   assign avm_local_bb1_st__byteenable = '0;
`endif

   // Control FSM with registered stream and Avalon outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                     <= S_IDLE;
         m_ready_out               <= 1'b1;
         m_valid_out               <= 1'b0;
         m_output_0                <= '0;
         avm_local_bb1_ld__address <= '0;
         avm_local_bb1_ld__read    <= 1'b0;
         acc                       <= '0;
         beat_cnt                  <= '0;
`ifdef HIFP_STORE_EN
         id_q                         <= '0;
         wave_q                       <= '0;
         size_q                       <= '0;
         avm_local_bb1_st__address    <= '0;
         avm_local_bb1_st__write      <= 1'b0;
         avm_local_bb1_st__writedata  <= '0;
         avm_local_bb1_st__byteenable <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (m_valid_in) begin
                  acc                       <= DATA_W'(m_input_fpid);
                  beat_cnt                  <= '0;
                  avm_local_bb1_ld__address <= m_input_wave + m_input_global_id_0 * 32'(WIN_BYTES);
                  avm_local_bb1_ld__read    <= 1'b1;
                  m_ready_out               <= 1'b0;
`ifdef HIFP_STORE_EN
                  id_q   <= m_input_global_id_0;
                  wave_q <= m_input_wave;
                  size_q <= m_input_global_size_0;
`endif
                  state <= S_REQ;
               end
            end
            S_REQ: begin
               if (!avm_local_bb1_ld__waitrequest) begin
                  avm_local_bb1_ld__read <= 1'b0;
                  state                  <= S_ACC;
               end
            end
            S_ACC: begin
               if (avm_local_bb1_ld__readdatavalid) begin
                  acc      <= acc_next;
                  beat_cnt <= beat_cnt + CNT_W'(1);
                  if (last_beat) begin
`ifdef HIFP_STORE_EN
                     avm_local_bb1_st__write      <= 1'b1;
                     avm_local_bb1_st__address    <= st_addr_c;
                     avm_local_bb1_st__writedata  <= {LANES{acc_next}};
                     avm_local_bb1_st__byteenable <= be_c;
                     state                        <= S_ST;
`else
                     m_valid_out <= 1'b1;
                     m_output_0  <= acc_next;
                     state       <= S_OUT;
`endif
                  end
               end
            end
`ifdef HIFP_STORE_EN
            S_ST: begin
               if (!avm_local_bb1_st__waitrequest) begin
                  avm_local_bb1_st__write <= 1'b0;
                  if (avm_local_bb1_st__writeack) begin
                     m_valid_out <= 1'b1;
                     m_output_0  <= acc;
                     state       <= S_OUT;
                  end else begin
                     state <= S_ACK;
                  end
               end
            end
            S_ACK: begin
               if (avm_local_bb1_st__writeack) begin
                  m_valid_out <= 1'b1;
                  m_output_0  <= acc;
                  state       <= S_OUT;
               end
            end
`endif
            S_OUT: begin
               if (m_ready_in) begin
                  m_valid_out <= 1'b0;
                  m_ready_out <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hifp_rtl_window.sv
// Self-checking bench: a sum instance (WIN_BEATS=1) and a hash instance
// (WIN_BEATS=4) driven from vector tables plus directed corner sequences.
`timescale 1ns/1ps
module tb_hifp_rtl_window;

   localparam int unsigned LANES = 16;
   localparam int unsigned WB    = 4;
`ifdef HIFP_STORE_EN
   localparam int ST_EXTRA = 1;
`else
   localparam int ST_EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- sum instance ----------------
   logic         s_valid_in, s_ready_out, s_valid_out, s_ready_in;
   logic [31:0]  s_id, s_wave, s_size, s_seed, s_out, s_ld_addr, s_st_addr;
   logic         s_ld_read, s_ld_wait, s_rdv, s_st_write, s_st_wait, s_st_ack;
   logic [4:0]   s_ld_bc;
   logic [511:0] s_rdata, s_st_wdata;
   logic [63:0]  s_st_be;

   assign s_ld_wait = 1'b0;
   assign s_st_wait = 1'b0;
   assign s_st_ack  = s_st_write;

   hifp_rtl_window #(.DATA_W(32), .MEM_W(512), .WIN_BEATS(1), .MODE(0), .ROT(5)) dut_sum (
      .clock(clk), .reset(rst),
      .m_valid_in(s_valid_in), .m_ready_out(s_ready_out),
      .m_input_global_id_0(s_id), .m_input_wave(s_wave),
      .m_input_global_size_0(s_size), .m_input_fpid(s_seed),
      .m_output_0(s_out), .m_valid_out(s_valid_out), .m_ready_in(s_ready_in),
      .avm_local_bb1_ld__address(s_ld_addr), .avm_local_bb1_ld__read(s_ld_read),
      .avm_local_bb1_ld__burstcount(s_ld_bc), .avm_local_bb1_ld__waitrequest(s_ld_wait),
      .avm_local_bb1_ld__readdata(s_rdata), .avm_local_bb1_ld__readdatavalid(s_rdv),
      .avm_local_bb1_st__address(s_st_addr), .avm_local_bb1_st__write(s_st_write),
      .avm_local_bb1_st__writedata(s_st_wdata), .avm_local_bb1_st__byteenable(s_st_be),
      .avm_local_bb1_st__waitrequest(s_st_wait), .avm_local_bb1_st__writeack(s_st_ack)
   );

   // one-beat responder: data follows the accepted read by one cycle
   bit s_pend = 0;
   initial begin
      s_rdv = 1'b0;
      forever begin
         @(negedge clk);
         s_rdv = 1'b0;
         if (rst) s_pend = 0;
         else begin
            if (s_pend) begin s_rdv = 1'b1; s_pend = 0; end
            if (s_ld_read) s_pend = 1;
         end
      end
   end

   // ---------------- hash instance ----------------
   logic         h_valid_in, h_ready_out, h_valid_out, h_ready_in;
   logic [31:0]  h_id, h_wave, h_size, h_seed, h_out, h_ld_addr, h_st_addr;
   logic         h_ld_read, h_ld_wait, h_rdv, h_st_write, h_st_wait, h_st_ack;
   logic [4:0]   h_ld_bc;
   logic [511:0] h_rdata, h_st_wdata;
   logic [63:0]  h_st_be;

   assign h_st_wait = 1'b0;
   assign h_st_ack  = h_st_write;

   hifp_rtl_window #(.DATA_W(32), .MEM_W(512), .WIN_BEATS(WB), .MODE(1), .ROT(5)) dut_hash (
      .clock(clk), .reset(rst),
      .m_valid_in(h_valid_in), .m_ready_out(h_ready_out),
      .m_input_global_id_0(h_id), .m_input_wave(h_wave),
      .m_input_global_size_0(h_size), .m_input_fpid(h_seed),
      .m_output_0(h_out), .m_valid_out(h_valid_out), .m_ready_in(h_ready_in),
      .avm_local_bb1_ld__address(h_ld_addr), .avm_local_bb1_ld__read(h_ld_read),
      .avm_local_bb1_ld__burstcount(h_ld_bc), .avm_local_bb1_ld__waitrequest(h_ld_wait),
      .avm_local_bb1_ld__readdata(h_rdata), .avm_local_bb1_ld__readdatavalid(h_rdv),
      .avm_local_bb1_st__address(h_st_addr), .avm_local_bb1_st__write(h_st_write),
      .avm_local_bb1_st__writedata(h_st_wdata), .avm_local_bb1_st__byteenable(h_st_be),
      .avm_local_bb1_st__waitrequest(h_st_wait), .avm_local_bb1_st__writeack(h_st_ack)
   );

   // burst responder with optional waitrequest stall and one-cycle beat gaps
   int          h_stall_left = 0;
   bit          h_gap = 0;
   logic [31:0] h_base = '0, h_step = '0;
   int          beats_left = 0, beat_idx = 0;
   bit          gap_tog = 0, req_seen = 0;
   logic [31:0] req_addr = '0;
   initial begin
      h_ld_wait = 1'b0;
      h_rdv     = 1'b0;
      h_rdata   = '0;
      forever begin
         @(negedge clk);
         h_rdv = 1'b0;
         if (rst) begin
            beats_left = 0; req_seen = 0; h_ld_wait = 1'b0;
         end else begin
            if (beats_left > 0) begin
               if (h_gap && gap_tog) gap_tog = 0;
               else begin
                  for (int l = 0; l < int'(LANES); l++)
                     h_rdata[l*32 +: 32] = h_base + h_step * 32'(beat_idx * int'(LANES) + l);
                  h_rdv = 1'b1; beat_idx++; beats_left--; gap_tog = 1;
               end
            end
            if (h_ld_read) begin
               if (!req_seen) begin req_addr = h_ld_addr; req_seen = 1; end
               else begin
                  check("ld_addr_stable", 64'(h_ld_addr), 64'(req_addr));
                  check("ld_burst_stable", 64'(h_ld_bc), 64'(WB));
               end
               if (h_stall_left > 0) begin h_ld_wait = 1'b1; h_stall_left--; end
               else begin
                  h_ld_wait = 1'b0; beats_left = WB; beat_idx = 0; gap_tog = 0; req_seen = 0;
               end
            end
         end
      end
   end

   function automatic logic [31:0] hash_model(input logic [31:0] seed, input logic [31:0] base,
                                               input logic [31:0] step);
      logic [31:0] a;
      a = seed;
      for (int b = 0; b < int'(WB); b++)
         for (int l = 0; l < int'(LANES); l++)
            a = {a[26:0], a[31:27]} ^ (base + step * 32'(b * int'(LANES) + l));
      return a;
   endfunction

   task automatic s_run(input logic [31:0] seed, input logic [31:0] word,
                        output logic [31:0] res, output int lat);
      s_rdata = {LANES{word}};
      @(negedge clk);
      s_seed = seed; s_valid_in = 1'b1;
      @(negedge clk);
      s_valid_in = 1'b0; lat = 1;
      while (!s_valid_out && lat < 100) begin @(negedge clk); lat++; end
      res = s_out;
      s_ready_in = 1'b1;
      @(negedge clk);
      s_ready_in = 1'b0;
   endtask

   task automatic h_start(input logic [31:0] id, input logic [31:0] wave,
                          input logic [31:0] size, input logic [31:0] seed,
                          output logic [31:0] addr);
      @(negedge clk);
      h_id = id; h_wave = wave; h_size = size; h_seed = seed; h_valid_in = 1'b1;
      @(negedge clk);
      h_valid_in = 1'b0;
      addr = h_ld_read ? h_ld_addr : 32'hDEAD_DEAD;
   endtask

   task automatic h_wait_valid(output int lat);
      lat = 1;
      while (!h_valid_out && lat < 200) begin @(negedge clk); lat++; end
   endtask

   task automatic h_run(input logic [31:0] id, input logic [31:0] wave, input logic [31:0] size,
                        input logic [31:0] seed, output logic [31:0] res, output int lat,
                        output logic [31:0] addr);
      h_start(id, wave, size, seed, addr);
      h_wait_valid(lat);
      res = h_out;
      h_ready_in = 1'b1;
      @(negedge clk);
      h_ready_in = 1'b0;
   endtask

   typedef struct { logic [31:0] seed, word, exp; } s_vec_t;
   typedef struct { logic [31:0] id, wave, seed, base, step, exp; } h_vec_t;

   s_vec_t      sv[4];
   h_vec_t      hv[4];
   logic [31:0] res, addr, held;
   int          lat;

   initial begin
      sv[0] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0010};
      sv[1] = '{32'hFFFF_FFF0, 32'h0000_0001, 32'h0000_0000};
      sv[2] = '{32'h0000_0005, 32'h1000_0000, 32'h0000_0005};
      sv[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
      hv[0] = '{32'd0, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'hA5A5_A5A5};
      hv[1] = '{32'd1, 32'h0000_0100, 32'h0000_0000, 32'h0, 32'h0, 32'h0000_0000};
      hv[2] = '{32'd7, 32'h0000_4000, 32'h0000_0000, 32'h1, 32'h0, 32'h0};
      hv[3] = '{32'd3, 32'h0000_0800, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0101_0101, 32'h0};
      hv[2].exp = hash_model(hv[2].seed, hv[2].base, hv[2].step);
      hv[3].exp = hash_model(hv[3].seed, hv[3].base, hv[3].step);

      s_valid_in = 0; s_ready_in = 0; s_id = 0; s_wave = 0; s_size = 0; s_seed = 0; s_rdata = '0;
      h_valid_in = 0; h_ready_in = 0; h_id = 0; h_wave = 0; h_size = 0; h_seed = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready_out", 64'(h_ready_out), 64'd1);
      check("rst_valid_out", 64'(h_valid_out), 64'd0);
      check("rst_read", 64'(h_ld_read), 64'd0);
      check("rst_output", 64'(h_out), 64'd0);
      check("rst_burstcount", 64'(h_ld_bc), 64'd4);
      check("rst_st_write", 64'(h_st_write), 64'd0);
      check("rst_sum_burstcount", 64'(s_ld_bc), 64'd1);
      rst = 1'b0;

      foreach (sv[i]) begin
         s_run(sv[i].seed, sv[i].word, res, lat);
         check($sformatf("sum_result[%0d]", i), 64'(res), 64'(sv[i].exp));
         check($sformatf("sum_latency[%0d]", i), 64'(lat), 64'(3 + ST_EXTRA));
      end

      foreach (hv[i]) begin
         h_base = hv[i].base; h_step = hv[i].step; h_gap = 0; h_stall_left = 0;
         h_run(hv[i].id, hv[i].wave, 32'd0, hv[i].seed, res, lat, addr);
         check($sformatf("hash_result[%0d]", i), 64'(res), 64'(hv[i].exp));
         check($sformatf("hash_latency[%0d]", i), 64'(lat), 64'(6 + ST_EXTRA));
         check($sformatf("hash_rd_addr[%0d]", i), 64'(addr), 64'(hv[i].wave + hv[i].id * 32'd256));
      end

      // waitrequest stall of 5 cycles plus a gap between every beat
      h_base = hv[3].base; h_step = hv[3].step; h_gap = 1; h_stall_left = 5;
      h_run(hv[3].id, hv[3].wave, 32'd0, hv[3].seed, res, lat, addr);
      check("stall_result", 64'(res), 64'(hv[3].exp));
      check("stall_latency", 64'(lat), 64'(14 + ST_EXTRA));
      check("stall_rd_addr", 64'(addr), 64'(32'h0800 + 32'd768));
      h_gap = 0;

      // downstream stall in OUT while a new item is offered
      h_base = hv[2].base; h_step = hv[2].step;
      h_start(hv[2].id, hv[2].wave, 32'd0, hv[2].seed, addr);
      h_wait_valid(lat);
      held = h_out;
      check("hold_first", 64'(held), 64'(hv[2].exp));
      h_id = 32'd9; h_valid_in = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("hold_valid", 64'(h_valid_out), 64'd1);
         check("hold_data", 64'(h_out), 64'(hv[2].exp));
         check("hold_ready_out", 64'(h_ready_out), 64'd0);
         check("hold_no_read", 64'(h_ld_read), 64'd0);
      end
      h_valid_in = 1'b0; h_ready_in = 1'b1;
      @(negedge clk);
      h_ready_in = 1'b0;
      check("after_hold_ready_out", 64'(h_ready_out), 64'd1);
      check("after_hold_valid", 64'(h_valid_out), 64'd0);
      repeat (3) begin
         @(negedge clk);
         check("after_hold_no_read", 64'(h_ld_read), 64'd0);
      end
      check("after_hold_output_kept", 64'(h_out), 64'(hv[2].exp));

      // reset in the middle of the beat phase
      h_base = hv[3].base; h_step = hv[3].step; h_gap = 1;
      h_start(hv[3].id, hv[3].wave, 32'd0, hv[3].seed, addr);
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 64'(h_ready_out), 64'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_read", 64'(h_ld_read), 64'd0);
      check("mid_rst_valid", 64'(h_valid_out), 64'd0);
      check("mid_rst_ready_out", 64'(h_ready_out), 64'd1);
      check("mid_rst_st_write", 64'(h_st_write), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      h_gap = 0;
      repeat (10) @(negedge clk);
      h_run(hv[3].id, hv[3].wave, 32'd0, hv[3].seed, res, lat, addr);
      check("post_rst_result", 64'(res), 64'(hv[3].exp));
      check("post_rst_latency", 64'(lat), 64'(6 + ST_EXTRA));

`ifdef HIFP_STORE_EN
      begin
         int w;
         h_base = '0; h_step = '0;
         h_start(32'd19, 32'h1000, 32'd32, 32'h1357_9BDF, addr);
         w = 1;
         while (!h_st_write && w < 200) begin @(negedge clk); w++; end
         check("st_write_seen", 64'(h_st_write), 64'd1);
         check("st_write_cycle", 64'(w), 64'd6);
         check("st_address", 64'(h_st_addr), 64'h3040);
         check("st_byteenable", 64'(h_st_be), 64'h0000_0000_0000_F000);
         check("st_wdata_lane3", 64'(h_st_wdata[3*32 +: 32]), 64'h1357_9BDF);
         check("st_wdata_lane0", 64'(h_st_wdata[31:0]), 64'h1357_9BDF);
         lat = w;
         while (!h_valid_out && lat < 200) begin @(negedge clk); lat++; end
         check("st_latency", 64'(lat), 64'd7);
         check("st_result", 64'(h_out), 64'h1357_9BDF);
         h_ready_in = 1'b1;
         @(negedge clk);
         h_ready_in = 1'b0;
      end
`else
      check("nost_st_write", 64'(h_st_write), 64'd0);
      check("nost_st_address", 64'(h_st_addr), 64'd0);
      check("nost_st_byteenable", 64'(h_st_be), 64'd0);
      check("nost_st_wdata", 64'(h_st_wdata[63:0]), 64'd0);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hifp_rtl_window.md
# hifp_rtl_window

Parametrised successor to the single-shot HIFP OpenCL RTL library function. Each work item fetches one window of WIN_BEATS wide words from local memory through a burst read master and folds the window into one DATA_W-bit fingerprint, by hash or by sum. It returns the fingerprint on the kernel-side valid/ready stream and can also write it back to local memory through a store master. It sits inside the HLS kernel datapath as an RTL library call, between the stall-valid pipeline and the local-memory arbiter.

## Interface
- DATA_W, 32, fingerprint and sample word width
- MEM_W, 512, local-memory data width; LANES = MEM_W/DATA_W words per beat
- WIN_BEATS, 4, beats per window, 1..16
- MODE, 1, fold: 0 = wrapping sum, 1 = rotate-XOR hash
- ROT, 5, hash left-rotate amount, 1..DATA_W-1
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- m_valid_in  in  1  work item offered
- m_ready_out  out  1  block can accept a work item
- m_input_global_id_0  in  32  work-item index
- m_input_wave  in  32  byte base address of the wave region
- m_input_global_size_0  in  32  work-item count; locates the result region
- m_input_fpid  in  32  fold seed; low DATA_W bits used
- m_output_0  out  DATA_W  fingerprint
- m_valid_out  out  1  fingerprint valid
- m_ready_in  in  1  downstream accepts fingerprint
- avm_local_bb1_ld__address  out  32  read byte address
- avm_local_bb1_ld__read  out  1  read request
- avm_local_bb1_ld__burstcount  out  5  equals WIN_BEATS
- avm_local_bb1_ld__waitrequest  in  1  slave stall
- avm_local_bb1_ld__readdata  in  MEM_W  read beat
- avm_local_bb1_ld__readdatavalid  in  1  beat valid
- avm_local_bb1_st__address  out  32  write byte address
- avm_local_bb1_st__write  out  1  write request, burstcount fixed at 1
- avm_local_bb1_st__writedata  out  MEM_W  result replicated in every lane
- avm_local_bb1_st__byteenable  out  MEM_W/8  enables only the target lane
- avm_local_bb1_st__waitrequest  in  1  slave stall
- avm_local_bb1_st__writeack  in  1  write committed

## Operation
- FSM states: IDLE, REQ, ACC, ST, ACK, OUT.
- **IDLE.** `m_ready_out` is 1 only in this state. When `m_valid_in` is 1, the block captures id, wave, size and seed, sets `acc` to the seed and moves to REQ.
- **REQ.** Drives `read` = 1 with address = wave + id·WIN_BEATS·MEM_W/8. Address and burstcount stay stable until a cycle where `waitrequest` = 0, then the block moves to ACC.
- **ACC.** Each `readdatavalid` beat is folded lane 0 (bits DATA_W-1:0) first, up to lane LANES-1.
  - Hash: acc = rotl(acc, ROT) ^ word.
  - Sum: acc = acc + word, modulo 2^DATA_W.
  - A beat counter counts to WIN_BEATS. On the last beat the block moves to ST, or to OUT when the store feature is compiled out.
- **ST.** Drives `write` = 1, address = wave + size·WIN_BEATS·MEM_W/8 + (id·DATA_W/8 rounded down to a MEM_W/8 boundary), and byteenable for lane id mod LANES. Held stable until `waitrequest` = 0.
- **ACK.** Waits for `writeack`. If `writeack` arrives in the same cycle the write is accepted, the block skips ACK and goes directly to OUT.
- **OUT.** `m_valid_out` = 1 and `m_output_0` = acc, both held until `m_ready_in` = 1, then the block returns to IDLE.
- `readdatavalid` and `writeack` outside ACC/ACK are ignored.
- Reset in any state returns the FSM to IDLE immediately. The surrounding system resets local memory together with this block, so no beats are in flight after reset.

## Timing
- All outputs reset to 0 except `m_ready_out`, which resets to 1. `ld__burstcount` is constant WIN_BEATS.
- Accept at cycle 0. `read` is asserted from cycle 1.
- `m_valid_out` rises one cycle after the last read beat with no store, or one cycle after `writeack` with store.
- Best-case latency, accept to valid_out, with zero waitrequest, beats back-to-back from cycle 2 and a same-cycle `writeack`: WIN_BEATS+2 without store, WIN_BEATS+3 with store.
- One work item is in flight at a time. Throughput is one item per latency plus the OUT stall.
- `m_output_0` is registered and holds its value until the next work item completes.

## Configuration
- `HIFP_STORE_EN` defined: ST and ACK states are present and the result is written back.
- `HIFP_STORE_EN` undefined: ST and ACK are removed, `st__write` is tied to 0, all `st` outputs are constant 0, and `st` inputs are ignored.

## Structure
- Package `hifp_pkg`: state enum, MODE_SUM/MODE_HASH constants, default ROT, and a rotl function.
- Sub-module `hifp_fold`: a combinational one-beat fold taking acc_in, beat, MODE and ROT, and producing acc_out. The FSM and Avalon masters live in the top.

## Test plan
- MODE=0, WIN_BEATS=1, seed 0, all lanes 1 -> `m_output_0` = 16, `m_valid_out` at cycle 3.
- MODE=1, seed 0xA5A5A5A5, all-zero window -> output = rotl(seed, 5·16·WIN_BEATS).
- `ld__waitrequest` held high for 5 cycles with `readdatavalid` gaps -> address and burstcount stable; output identical to the no-stall run.
- HIFP_STORE_EN, id 19, wave 0x1000, size 32, WIN_BEATS 4 -> `st__address` = 0x1000 + 0x2000 + 0x40, byteenable = 0xF << 12.
- `m_ready_in` low for 10 cycles in OUT -> valid and data held; `m_ready_out` stays 0; a new `m_valid_in` is not accepted.
- Reset asserted mid-ACC -> next cycle the FSM is in IDLE, `read`/`write`/`m_valid_out` = 0, `m_ready_out` = 1; the next item completes correctly.
